sh7034_ibus_copy: RTL and testbench
===================================

Name: sh7034_ibus_copy

Overview:
- Internal-bus initiator: a small block-copy engine that masters IBUS transactions towards the on-chip RAM and other IBUS responders.
- Firmware-side control programs source address, destination address, element count and element size, then pulses START.
- The block performs read-then-write element by element, generating byte lanes (big-endian) and honouring responder BUSY/ACT.
- It sits beside the CPU core as a second IBUS requester, behind the core's bus mux.

Parameters:
- CNT_W, 16, width of element counter (max elements = 2^CNT_W-1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R=1.
- CE_F  in  1  falling-phase clock enable; used only for read-data capture.
- SRC_A  in  28  source start address; sampled at START.
- DST_A  in  28  destination start address; sampled at START.
- COUNT  in  CNT_W  number of elements; sampled at START.
- SIZE  in  2  element size: 0=byte, 1=word, 2=long, 3=reserved (treated as error).
- START  in  1  start request, level-sampled on a CE_R cycle while idle.
- ABORT  in  1  abort request, sampled on CE_R.
- IBUS_A  out  28  transaction address.
- IBUS_DO  out  32  write data.
- IBUS_DI  in  32  read data from responder.
- IBUS_BA  out  4  byte-lane enables; BA[3] = lane at address offset 0.
- IBUS_WE  out  1  write strobe.
- IBUS_REQ  out  1  transaction request.
- IBUS_BUSY  in  1  responder wait.
- IBUS_ACT  in  1  responder claims address.
- XFER_BUSY  out  1  engine active.
- XFER_DONE  out  1  one-CLK pulse on normal completion.
- XFER_ERR  out  1  sticky error; cleared by the next accepted START.
- XFER_REM  out  CNT_W  elements remaining.

Behaviour:
- Reset: all outputs are 0; the FSM is in IDLE; internal address and count registers are 0.
- FSM states: IDLE, RD, RCAP, WR, FIN.
- State changes occur only on CE_R, except RD->RCAP capture, which is described below.
- IDLE, START=1: latch SRC/DST/COUNT/SIZE, clear XFER_ERR, set XFER_BUSY.
  - COUNT=0: go to FIN with no bus activity.
  - SIZE=3: set XFER_ERR and go to FIN.
  - Misaligned start (word with A[0]=1, or long with A[1:0]!=0, for either address): set XFER_ERR and go to FIN.
  - Otherwise go to RD.
- Lane generation, from address bits [1:0]:
  - byte: BA = 4'b1000 >> A[1:0].
  - word: A[1]=0 gives 1100; A[1]=1 gives 0011.
  - long: 1111.
- RD: IBUS_REQ=1, WE=0, A=src, BA per the rule above.
  - The phase is accepted on a CE_R with BUSY=0 and ACT=1.
  - On acceptance, go to RCAP.
- RCAP: IBUS_REQ=0.
  - On the first CE_F after acceptance, capture IBUS_DI, extract the addressed lane(s) and right-justify them.
  - Replicate the element across all four lanes: byte x4, word x2.
  - On the next CE_R, go to WR.
- WR: IBUS_REQ=1, WE=1, A=dst, BA per the destination address, DO = replicated data.
  - The phase is accepted on a CE_R with BUSY=0 and ACT=1.
  - On acceptance: src += size bytes, dst += size bytes (28-bit wrap), REM -= 1.
  - If REM reaches 0, go to FIN; else go to RD.
- BUSY=1: hold A/DO/BA/WE/REQ stable; no timeout.
- ACT=0 on any CE_R while REQ=1 (unmapped address): set XFER_ERR, drop REQ, go to FIN.
- ABORT=1 on CE_R in any non-IDLE state: finish the current CE_R without starting a new phase, drop REQ, go to FIN.
  - XFER_ERR and XFER_DONE are not set.
  - The remaining count stays visible on XFER_REM.
- FIN: XFER_DONE pulses for one CLK only if there was no error and no abort; XFER_BUSY clears; go to IDLE.
- START while busy is ignored.
- START and ABORT together in IDLE: START wins; ABORT is ignored when idle.
- Reset mid-transfer: immediate return to reset values; no further bus phases.
- Throughput: with BUSY=0 and CE_R every CLK, one element takes 3 CE_R cycles (RD, RCAP, WR).

Test Plan:
- Long copy: SRC=F000100, DST=F000200, COUNT=4, SIZE=2, BUSY=0.
  - Required: 4 reads and 4 writes with BA=1111, addresses advancing by 4.
  - XFER_DONE pulses once; XFER_REM=0.
- Byte copy: SRC=F000101, DST=F000203, COUNT=1, source word 0x11223344.
  - Required: read BA=0100; write BA=0001, DO=0x22222222.
- Word copy with BUSY=1 for 3 CE_R cycles during WR.
  - Required: A/DO/BA held stable through the wait, then accepted.
  - Total element time extends by 3 CE_R cycles.
- Unmapped source (ACT=0) on the first RD.
  - Required: XFER_ERR=1, no write phase, no XFER_DONE; the next START clears XFER_ERR.
- ABORT asserted during the second WR of COUNT=5.
  - Required: REQ drops, XFER_REM=4, XFER_BUSY=0, XFER_DONE=0, XFER_ERR=0.
- COUNT=0, misaligned long (SRC A[1:0]=2), and RST pulsed mid-transfer.
  - COUNT=0: XFER_DONE with no bus phases.
  - Misaligned long: error with no bus phases.
  - RST: all outputs 0 at once.

Source files
------------

// File: rtl/sh7034_ibus_copy.sv
// IBUS block-copy initiator: element-wise read-then-write between two address
// ranges, with big-endian lane generation, BUSY/ACT handshake and abort.
module sh7034_ibus_copy #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE_R,
    input  logic             CE_F,
    input  logic [27:0]      SRC_A,
    input  logic [27:0]      DST_A,
    input  logic [CNT_W-1:0] COUNT,
    input  logic [1:0]       SIZE,
    input  logic             START,
    input  logic             ABORT,
    output logic [27:0]      IBUS_A,
    output logic [31:0]      IBUS_DO,
    input  logic [31:0]      IBUS_DI,
    output logic [3:0]       IBUS_BA,
    output logic             IBUS_WE,
    output logic             IBUS_REQ,
    input  logic             IBUS_BUSY,
    input  logic             IBUS_ACT,
    output logic             XFER_BUSY,
    output logic             XFER_DONE,
    output logic             XFER_ERR,
    output logic [CNT_W-1:0] XFER_REM
);

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RCAP,
        S_WR,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       size_q, size_d;
    logic [DW-1:0]    data_q, data_d;
    logic             cap_q, cap_d;
    logic             abrt_q, abrt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AW-1:0]    a_q, a_d;
    logic [DW-1:0]    do_q, do_d;
    logic [3:0]       ba_q, ba_d;
    logic             we_q, we_d;
    logic             req_q, req_d;

    logic [AW-1:0]    addr_inc;
    logic [AW-1:0]    src_inc;
    logic [AW-1:0]    dst_inc;
    logic [1:0]       noff;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_word;
    logic [DW-1:0]    rd_repl;
    logic [DW-1:0]    data_now;
    logic             misalign;

    // Big-endian lane enables: BA[3] is the byte at offset 0.
    function automatic logic [3:0] lanes(input logic [1:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    lanes = 4'b1000 >> a;
            2'd1:    lanes = a[1] ? 4'b0011 : 4'b1100;
            default: lanes = 4'b1111;
        endcase
    endfunction

    // Address stepping and right-justified, lane-replicated read data.
    always_comb begin
        addr_inc = AW'(1) << size_q;
        src_inc  = src_q + addr_inc;
        dst_inc  = dst_q + addr_inc;
        noff     = ~src_q[1:0];
        rd_byte  = 8'(IBUS_DI >> {noff, 3'b000});
        rd_word  = src_q[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
        case (size_q)
            2'd0:    rd_repl = {4{rd_byte}};
            2'd1:    rd_repl = {2{rd_word}};
            default: rd_repl = IBUS_DI;
        endcase
        data_now = cap_q ? data_q : rd_repl;
        misalign = ((SIZE == 2'd1) && (SRC_A[0] || DST_A[0])) ||
                   ((SIZE == 2'd2) && ((SRC_A[1:0] != 2'd0) || (DST_A[1:0] != 2'd0)));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        size_d  = size_q;
        data_d  = data_q;
        cap_d   = cap_q;
        abrt_d  = abrt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        a_d     = a_q;
        do_d    = do_q;
        ba_d    = ba_q;
        we_d    = we_q;
        req_d   = req_q;

        if ((state_q == S_RCAP) && CE_F && !cap_q) begin
            data_d = rd_repl;
            cap_d  = 1'b1;
        end

        if (CE_R) begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        src_d  = SRC_A;
                        dst_d  = DST_A;
                        rem_d  = COUNT;
                        size_d = SIZE;
                        err_d  = 1'b0;
                        abrt_d = 1'b0;
                        busy_d = 1'b1;
                        if (COUNT == '0) begin
                            state_d = S_FIN;
                        end else if ((SIZE == 2'd3) || misalign) begin
                            err_d   = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            state_d = S_RD;
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            a_d     = SRC_A;
                            ba_d    = lanes(SRC_A[1:0], SIZE);
                        end
                    end
                end
                S_RD, S_WR: begin
                    if (ABORT) begin
                        abrt_d  = 1'b1;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = S_FIN;
                    end else if (!IBUS_ACT) begin
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = S_FIN;
                    end else if (!IBUS_BUSY) begin
                        req_d = 1'b0;
                        we_d  = 1'b0;
                        if (state_q == S_RD) begin
                            cap_d   = 1'b0;
                            state_d = S_RCAP;
                        end else begin
                            src_d = src_inc;
                            dst_d = dst_inc;
                            rem_d = rem_q - CNT_W'(1);
                            if (rem_q == CNT_W'(1)) begin
                                state_d = S_FIN;
                            end else begin
                                state_d = S_RD;
                                req_d   = 1'b1;
                                a_d     = src_inc;
                                ba_d    = lanes(src_inc[1:0], size_q);
                            end
                        end
                    end
                end
                S_RCAP: begin
                    if (ABORT) begin
                        abrt_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_WR;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        a_d     = dst_q;
                        ba_d    = lanes(dst_q[1:0], size_q);
                        do_d    = data_now;
                    end
                end
                S_FIN: begin
                    busy_d  = 1'b0;
                    done_d  = !err_q && !abrt_q && !ABORT;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            size_q  <= '0;
            data_q  <= '0;
            cap_q   <= 1'b0;
            abrt_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            do_q    <= '0;
            ba_q    <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            size_q  <= size_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            abrt_q  <= abrt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            do_q    <= do_d;
            ba_q    <= ba_d;
            we_q    <= we_d;
            req_q   <= req_d;
        end
    end

    assign IBUS_A    = a_q;
    assign IBUS_DO   = do_q;
    assign IBUS_BA   = ba_q;
    assign IBUS_WE   = we_q;
    assign IBUS_REQ  = req_q;
    assign XFER_BUSY = busy_q;
    assign XFER_DONE = done_q;
    assign XFER_ERR  = err_q;
    assign XFER_REM  = rem_q;

endmodule

// File: tb/tb_sh7034_ibus_copy.sv
// Bench for sh7034_ibus_copy: responder model, bus monitor and a transaction-level
// reference model of the copy sequence.
module tb_sh7034_ibus_copy;

    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [27:0] a;
        logic        we;
        logic [3:0]  ba;
        logic [31:0] d;
    } txn_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CE_R;
    logic             CE_F;
    logic [27:0]      SRC_A;
    logic [27:0]      DST_A;
    logic [CNT_W-1:0] COUNT;
    logic [1:0]       SIZE;
    logic             START;
    logic             ABORT;
    logic [27:0]      IBUS_A;
    logic [31:0]      IBUS_DO;
    logic [31:0]      IBUS_DI;
    logic [3:0]       IBUS_BA;
    logic             IBUS_WE;
    logic             IBUS_REQ;
    logic             IBUS_BUSY;
    logic             IBUS_ACT;
    logic             XFER_BUSY;
    logic             XFER_DONE;
    logic             XFER_ERR;
    logic [CNT_W-1:0] XFER_REM;

    sh7034_ibus_copy #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
        .SRC_A(SRC_A), .DST_A(DST_A), .COUNT(COUNT), .SIZE(SIZE),
        .START(START), .ABORT(ABORT),
        .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_DI(IBUS_DI), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .XFER_BUSY(XFER_BUSY), .XFER_DONE(XFER_DONE), .XFER_ERR(XFER_ERR), .XFER_REM(XFER_REM)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Test-owned controls
    logic        force_en   = 1'b0;
    logic [31:0] force_word = 32'h0;
    logic        rnd_mode   = 1'b0;
    logic        force_ce   = 1'b0;
    int          stall_total = 0;

    // Driver/monitor-owned state
    int   stall_used = 0;
    int   done_total = 0;
    int   done_cyc   = 0;
    int   req_total  = 0;
    int   we_total   = 0;
    int   hold_cmp   = 0;
    int   hold_bad   = 0;
    logic hold_v     = 1'b0;
    logic [64:0] hold_snap = '0;
    txn_t obs_q[$];

    // Expectations for the current transfer
    txn_t exp_q[$];
    logic exp_err;
    logic [CNT_W-1:0] exp_rem;
    int   obs_base, done_base, req_base, we_base, s_cyc;

    function automatic logic [31:0] mem_word(input logic [27:0] a);
        mem_word = {a[15:2], 2'b01, ~a[15:2], 2'b10};
    endfunction

    function automatic logic [3:0] model_ba(input logic [27:0] a, input int nb);
        logic [3:0] r = 4'b0000;
        for (int k = 0; k < nb; k++) r[3 - (int'(a[1:0]) + k)] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] w, input logic [27:0] a, input int nb);
        logic [31:0] r = '0;
        int o;
        for (int l = 0; l < 4; l++) begin
            o = int'(a[1:0]) + (l % nb);
            r[31 - 8*l -: 8] = w[31 - 8*o -: 8];
        end
        return r;
    endfunction

    always_comb IBUS_DI  = force_en ? force_word : mem_word(IBUS_A);
    always_comb IBUS_ACT = (IBUS_A[27:24] != 4'h0);

    always @(posedge CLK) cyc <= cyc + 1;

    // Responder wait states and clock-enable pattern
    initial begin
        IBUS_BUSY = 1'b0;
        CE_R = 1'b1;
        CE_F = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            CE_R = (rnd_mode && !force_ce) ? ($urandom_range(3) != 0) : 1'b1;
            if (IBUS_REQ && IBUS_WE && (stall_used < stall_total)) begin
                IBUS_BUSY = 1'b1;
                stall_used++;
            end else if (rnd_mode) begin
                IBUS_BUSY = ($urandom_range(3) == 0);
            end else begin
                IBUS_BUSY = 1'b0;
            end
        end
    end

    // Bus monitor: records accepted phases, pulses and hold stability
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (XFER_DONE) begin done_total++; done_cyc = cyc; end
            if (IBUS_REQ) req_total++;
            if (IBUS_REQ && IBUS_WE) we_total++;
            if (IBUS_REQ && hold_v) begin
                hold_cmp++;
                if ({IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE} !== hold_snap) hold_bad++;
            end
            hold_v    = IBUS_REQ && IBUS_BUSY && IBUS_ACT && !RST;
            hold_snap = {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE};
            if (IBUS_REQ && CE_R && !IBUS_BUSY && IBUS_ACT && !ABORT && !RST)
                obs_q.push_back('{a: IBUS_A, we: IBUS_WE, ba: IBUS_BA,
                                  d: (IBUS_WE ? IBUS_DO : 32'h0)});
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [27:0] s, input logic [27:0] d,
                          input logic [CNT_W-1:0] n, input logic [1:0] sz);
        int  nb = 1 << sz;
        logic bad_align;
        exp_q.delete();
        bad_align = (sz == 2'd3) || (((s[1:0] % nb) != 0) || ((d[1:0] % nb) != 0));
        if (n == 0) begin
            exp_err = 1'b0;
            exp_rem = '0;
        end else if (bad_align) begin
            exp_err = 1'b1;
            exp_rem = n;
        end else begin
            exp_err = 1'b0;
            exp_rem = '0;
            for (int i = 0; i < int'(n); i++) begin
                logic [27:0] sa = s + 28'(i * nb);
                logic [27:0] da = d + 28'(i * nb);
                logic [31:0] w  = force_en ? force_word : mem_word(sa);
                exp_q.push_back('{a: sa, we: 1'b0, ba: model_ba(sa, nb), d: 32'h0});
                exp_q.push_back('{a: da, we: 1'b1, ba: model_ba(da, nb), d: model_data(w, sa, nb)});
            end
        end
        obs_base  = obs_q.size();
        done_base = done_total;
        req_base  = req_total;
        we_base   = we_total;
        SRC_A = s; DST_A = d; COUNT = n; SIZE = sz;
        force_ce = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #2;
        s_cyc = cyc;
        START = 1'b0;
        force_ce = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        @(negedge CLK);
        while (XFER_BUSY && (k < budget)) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_idle"}, 72'(XFER_BUSY), 72'(0));
        repeat (2) @(negedge CLK);
        #3;
    endtask

    task automatic verify(input string tag, input int lat);
        int nobs;
        wait_idle(tag, 400);
        nobs = obs_q.size() - obs_base;
        check({tag, "_ntxn"}, 72'(nobs), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < nobs)
                check($sformatf("%s_txn%0d", tag, i), 72'(obs_q[obs_base + i]), 72'(exp_q[i]));
        check({tag, "_err"}, 72'(XFER_ERR), 72'(exp_err));
        check({tag, "_rem"}, 72'(XFER_REM), 72'(exp_rem));
        check({tag, "_done"}, 72'(done_total - done_base), 72'(exp_err ? 0 : 1));
        if (exp_q.size() == 0)
            check({tag, "_nobus"}, 72'(req_total - req_base), 72'(0));
        if (lat >= 0)
            check({tag, "_lat"}, 72'(done_cyc - s_cyc), 72'(lat));
    endtask

    initial begin
        int hc, hb, wr_seen, found, rb;
        logic prev_wr;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0;
        SRC_A = '0; DST_A = '0; COUNT = '0; SIZE = '0;
        repeat (3) @(negedge CLK);
        check("rst_req",  72'(IBUS_REQ),  72'(0));
        check("rst_bus",  72'({IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE}), 72'(0));
        check("rst_stat", 72'({XFER_BUSY, XFER_DONE, XFER_ERR, XFER_REM}), 72'(0));
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        #3;

        // Long copy
        launch(28'hF000100, 28'hF000200, 16'd4, 2'd2);
        verify("long", 13);

        // Byte copy with a fixed source word
        force_en = 1'b1; force_word = 32'h11223344;
        launch(28'hF000101, 28'hF000203, 16'd1, 2'd0);
        verify("byte", 4);
        if (obs_q.size() >= obs_base + 2) begin
            check("byte_rd_ba", 72'(obs_q[obs_base].ba), 72'(4'b0100));
            check("byte_wr_ba", 72'(obs_q[obs_base + 1].ba), 72'(4'b0001));
            check("byte_wr_do", 72'(obs_q[obs_base + 1].d), 72'(32'h22222222));
        end
        force_en = 1'b0;

        // Word copy with 3 wait states on the first write
        hc = hold_cmp; hb = hold_bad;
        stall_total = stall_total + 3;
        launch(28'hF000302, 28'hF000400, 16'd2, 2'd1);
        verify("wstall", 10);
        check("wstall_holds", 72'(hold_cmp - hc), 72'(3));
        check("wstall_stable", 72'(hold_bad - hb), 72'(0));

        // Unmapped source, then a clean START clears the error
        launch(28'h0000100, 28'hF000200, 16'd2, 2'd2);
        wait_idle("unmap", 50);
        check("unmap_err",   72'(XFER_ERR), 72'(1));
        check("unmap_nowr",  72'(we_total - we_base), 72'(0));
        check("unmap_ntxn",  72'(obs_q.size() - obs_base), 72'(0));
        check("unmap_done",  72'(done_total - done_base), 72'(0));
        launch(28'hF000500, 28'hF000600, 16'd1, 2'd2);
        check("errclr", 72'(XFER_ERR), 72'(0));
        verify("errclr", 4);

        // Abort during the second write of five
        launch(28'hF000700, 28'hF000800, 16'd5, 2'd2);
        wr_seen = 0; found = 0; prev_wr = 1'b0;
        for (int k = 0; (k < 100) && (found == 0); k++) begin
            @(negedge CLK);
            if (IBUS_REQ && IBUS_WE && !prev_wr) wr_seen++;
            prev_wr = IBUS_REQ && IBUS_WE;
            if (wr_seen == 2) begin
                #1 ABORT = 1'b1;
                @(posedge CLK);
                #1 ABORT = 1'b0;
                found = 1;
            end
        end
        check("abort_found", 72'(found), 72'(1));
        wait_idle("abort", 50);
        check("abort_req",  72'(IBUS_REQ), 72'(0));
        check("abort_rem",  72'(XFER_REM), 72'(4));
        check("abort_busy", 72'(XFER_BUSY), 72'(0));
        check("abort_err",  72'(XFER_ERR), 72'(0));
        check("abort_done", 72'(done_total - done_base), 72'(0));
        check("abort_ntxn", 72'(obs_q.size() - obs_base), 72'(3));

        // Degenerate starts
        launch(28'hF000100, 28'hF000200, 16'd0, 2'd2);
        verify("cnt0", 1);
        launch(28'hF000102, 28'hF000200, 16'd3, 2'd2);
        verify("misal", -1);
        launch(28'hF000100, 28'hF000200, 16'd2, 2'd3);
        verify("size3", -1);

        // Reset in the middle of a transfer
        launch(28'hF000100, 28'hF000900, 16'd8, 2'd2);
        repeat (7) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        check("mrst_req",  72'(IBUS_REQ), 72'(0));
        check("mrst_bus",  72'({IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE}), 72'(0));
        check("mrst_stat", 72'({XFER_BUSY, XFER_DONE, XFER_ERR, XFER_REM}), 72'(0));
        @(negedge CLK);
        #1 RST = 1'b0;
        rb = req_total;
        repeat (10) @(negedge CLK);
        #3;
        check("mrst_quiet", 72'(req_total - rb), 72'(0));
        check("mrst_idle",  72'(XFER_BUSY), 72'(0));

        // Randomized copies with random wait states and clock enables
        rnd_mode = 1'b1;
        for (int it = 0; it < 6; it++) begin
            logic [1:0]  sz = 2'($urandom_range(2));
            logic [27:0] msk = ~(28'(1 << sz) - 28'd1);
            logic [27:0] s = {4'hF, 8'h00, 16'($urandom)} & msk;
            logic [27:0] d = {4'hF, 8'h10, 16'($urandom)} & msk;
            launch(s, d, 16'($urandom_range(6, 1)), sz);
            verify($sformatf("rnd%0d", it), -1);
        end
        rnd_mode = 1'b0;
        check("hold_total", 72'(hold_bad), 72'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
